// File: rtl/translation_lookaside_buffer.sv
// Fully associative joint TLB: registered lookup (lowest matching index wins),
// synchronous write port and registered read port, all on stored state only.
module translation_lookaside_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_tlbReq_i,
  input  logic [18:0]      data_vpn2_i,
  input  logic             data_oddPage_i,
  input  logic [7:0]       data_asid_i,
  output logic             data_hit_o,
  output logic [IDX_W-1:0] data_index_o,
  output logic [19:0]      data_pfn_o,
  output logic [2:0]       data_c_o,
  output logic             data_d_o,
  output logic             data_v_o,
  input  logic             w_enable_i,
  input  logic [IDX_W-1:0] w_index_i,
  input  logic [18:0]      w_vpn2_i,
  input  logic [7:0]       w_asid_i,
  input  logic [11:0]      w_mask_i,
  input  logic             w_g_i,
  input  logic [19:0]      w_pfn0_i,
  input  logic [19:0]      w_pfn1_i,
  input  logic [4:0]       w_flags0_i,
  input  logic [4:0]       w_flags1_i,
  input  logic             r_enable_i,
  input  logic [IDX_W-1:0] r_index_i,
  output logic [18:0]      r_vpn2_o,
  output logic [7:0]       r_asid_o,
  output logic [11:0]      r_mask_o,
  output logic             r_g_o,
  output logic [19:0]      r_pfn0_o,
  output logic [4:0]       r_flags0_o,
  output logic [19:0]      r_pfn1_o,
  output logic [4:0]       r_flags1_o
);

  logic [ENTRIES-1:0] r_occ;
  logic [18:0]        r_vpn2   [ENTRIES];
  logic [7:0]         r_asid   [ENTRIES];
  logic [11:0]        r_mask   [ENTRIES];
  logic [ENTRIES-1:0] r_g;
  logic [19:0]        r_pfn0   [ENTRIES];
  logic [19:0]        r_pfn1   [ENTRIES];
  logic [4:0]         r_flags0 [ENTRIES];
  logic [4:0]         r_flags1 [ENTRIES];

  logic [ENTRIES-1:0] w_match;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [19:0]        w_pfn;
  logic [4:0]         w_flags;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
      r_g   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_vpn2[i]   <= '0;
        r_asid[i]   <= '0;
        r_mask[i]   <= '0;
        r_pfn0[i]   <= '0;
        r_pfn1[i]   <= '0;
        r_flags0[i] <= '0;
        r_flags1[i] <= '0;
      end
    end else if (w_enable_i) begin
      r_occ[w_index_i]    <= 1'b1;
      r_vpn2[w_index_i]   <= w_vpn2_i;
      r_asid[w_index_i]   <= w_asid_i;
      r_mask[w_index_i]   <= w_mask_i;
      r_g[w_index_i]      <= w_g_i;
      r_pfn0[w_index_i]   <= w_pfn0_i;
      r_pfn1[w_index_i]   <= w_pfn1_i;
      r_flags0[w_index_i] <= w_flags0_i;
      r_flags1[w_index_i] <= w_flags1_i;
    end
  end

  // Mask is deliberately ignored: only 4 KB pages are matched.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < ENTRIES; i++)
      w_match[i] = r_occ[i] && (r_vpn2[i] == data_vpn2_i) &&
                   (r_g[i] || (r_asid[i] == data_asid_i));
  end

  // Scan downward so the lowest matching index is the last one assigned.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_pfn   = '0;
    w_flags = '0;
    if (w_hit) begin
      w_pfn   = data_oddPage_i ? r_pfn1[w_idx]   : r_pfn0[w_idx];
      w_flags = data_oddPage_i ? r_flags1[w_idx] : r_flags0[w_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_hit_o   <= 1'b0;
      data_index_o <= '0;
      data_pfn_o   <= '0;
      data_c_o     <= '0;
      data_d_o     <= 1'b0;
      data_v_o     <= 1'b0;
    end else if (data_tlbReq_i) begin
      data_hit_o   <= w_hit;
      data_index_o <= w_idx;
      data_pfn_o   <= w_pfn;
      data_c_o     <= w_flags[4:2];
      data_d_o     <= w_flags[1];
      data_v_o     <= w_flags[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vpn2_o   <= '0;
      r_asid_o   <= '0;
      r_mask_o   <= '0;
      r_g_o      <= 1'b0;
      r_pfn0_o   <= '0;
      r_flags0_o <= '0;
      r_pfn1_o   <= '0;
      r_flags1_o <= '0;
    end else if (r_enable_i) begin
      r_vpn2_o   <= r_vpn2[r_index_i];
      r_asid_o   <= r_asid[r_index_i];
      r_mask_o   <= r_mask[r_index_i];
      r_g_o      <= r_g[r_index_i];
      r_pfn0_o   <= r_pfn0[r_index_i];
      r_flags0_o <= r_flags0[r_index_i];
      r_pfn1_o   <= r_pfn1[r_index_i];
      r_flags1_o <= r_flags1[r_index_i];
    end
  end

endmodule

// File: tb/tb_translation_lookaside_buffer.sv
// Bench for translation_lookaside_buffer: directed vector table, mid-stream
// reset sequence, then random traffic against an array-search reference model.
module tb_translation_lookaside_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_tlbReq_i = 1'b0;
  logic [18:0] data_vpn2_i = '0;
  logic        data_oddPage_i = 1'b0;
  logic [7:0]  data_asid_i = '0;
  logic        data_hit_o;
  logic [3:0]  data_index_o;
  logic [19:0] data_pfn_o;
  logic [2:0]  data_c_o;
  logic        data_d_o, data_v_o;
  logic        w_enable_i = 1'b0;
  logic [3:0]  w_index_i = '0;
  logic [18:0] w_vpn2_i = '0;
  logic [7:0]  w_asid_i = '0;
  logic [11:0] w_mask_i = '0;
  logic        w_g_i = 1'b0;
  logic [19:0] w_pfn0_i = '0, w_pfn1_i = '0;
  logic [4:0]  w_flags0_i = '0, w_flags1_i = '0;
  logic        r_enable_i = 1'b0;
  logic [3:0]  r_index_i = '0;
  logic [18:0] r_vpn2_o;
  logic [7:0]  r_asid_o;
  logic [11:0] r_mask_o;
  logic        r_g_o;
  logic [19:0] r_pfn0_o, r_pfn1_o;
  logic [4:0]  r_flags0_o, r_flags1_o;

  translation_lookaside_buffer #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .data_tlbReq_i(data_tlbReq_i), .data_vpn2_i(data_vpn2_i),
    .data_oddPage_i(data_oddPage_i), .data_asid_i(data_asid_i),
    .data_hit_o(data_hit_o), .data_index_o(data_index_o), .data_pfn_o(data_pfn_o),
    .data_c_o(data_c_o), .data_d_o(data_d_o), .data_v_o(data_v_o),
    .w_enable_i(w_enable_i), .w_index_i(w_index_i), .w_vpn2_i(w_vpn2_i),
    .w_asid_i(w_asid_i), .w_mask_i(w_mask_i), .w_g_i(w_g_i),
    .w_pfn0_i(w_pfn0_i), .w_pfn1_i(w_pfn1_i),
    .w_flags0_i(w_flags0_i), .w_flags1_i(w_flags1_i),
    .r_enable_i(r_enable_i), .r_index_i(r_index_i),
    .r_vpn2_o(r_vpn2_o), .r_asid_o(r_asid_o), .r_mask_o(r_mask_o), .r_g_o(r_g_o),
    .r_pfn0_o(r_pfn0_o), .r_flags0_o(r_flags0_o),
    .r_pfn1_o(r_pfn1_o), .r_flags1_o(r_flags1_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Directed vectors: stimulus for one edge and the outputs expected after it.
  typedef struct {
    bit        we;  bit [3:0] widx; bit [18:0] wvpn; bit [7:0] wasid; bit wg;
    bit [19:0] wpfn0; bit [4:0] wf0; bit [19:0] wpfn1; bit [4:0] wf1;
    bit        req; bit [18:0] vpn; bit [7:0] asid; bit odd;
    bit        re;  bit [3:0] ridx;
    bit        ehit; bit [3:0] eidx; bit [19:0] epfn; bit [2:0] ec; bit ed; bit ev;
    bit [18:0] ervpn;
  } vec_t;

  vec_t tbl[15];

  task automatic drive_vec(input vec_t v);
    w_enable_i = v.we;  w_index_i = v.widx; w_vpn2_i = v.wvpn; w_asid_i = v.wasid;
    w_g_i = v.wg; w_mask_i = 12'h000; w_pfn0_i = v.wpfn0; w_flags0_i = v.wf0;
    w_pfn1_i = v.wpfn1; w_flags1_i = v.wf1;
    data_tlbReq_i = v.req; data_vpn2_i = v.vpn; data_asid_i = v.asid;
    data_oddPage_i = v.odd;
    r_enable_i = v.re; r_index_i = v.ridx;
  endtask

  function automatic vec_t mk(
      bit we, bit [3:0] widx, bit [18:0] wvpn, bit [7:0] wasid, bit wg,
      bit [19:0] wpfn0, bit [4:0] wf0, bit [19:0] wpfn1, bit [4:0] wf1,
      bit req, bit [18:0] vpn, bit [7:0] asid, bit odd, bit re, bit [3:0] ridx,
      bit ehit, bit [3:0] eidx, bit [19:0] epfn, bit [2:0] ec, bit ed, bit ev,
      bit [18:0] ervpn);
    vec_t v;
    v.we = we; v.widx = widx; v.wvpn = wvpn; v.wasid = wasid; v.wg = wg;
    v.wpfn0 = wpfn0; v.wf0 = wf0; v.wpfn1 = wpfn1; v.wf1 = wf1;
    v.req = req; v.vpn = vpn; v.asid = asid; v.odd = odd; v.re = re; v.ridx = ridx;
    v.ehit = ehit; v.eidx = eidx; v.epfn = epfn; v.ec = ec; v.ed = ed; v.ev = ev;
    v.ervpn = ervpn;
    return v;
  endfunction

  // Reference model: a plain table searched with an array locator.
  typedef struct {
    bit occ; bit [18:0] vpn2; bit [7:0] asid; bit [11:0] mask; bit g;
    bit [19:0] pfn0; bit [4:0] f0; bit [19:0] pfn1; bit [4:0] f1;
  } ent_t;

  ent_t m[16];
  ent_t e_r;
  bit        e_hit;
  bit [3:0]  e_idx;
  bit [19:0] e_pfn;
  bit [4:0]  e_fl;

  task automatic model_reset();
    ent_t z;
    z = '{default: '0};
    for (int i = 0; i < 16; i++) m[i] = z;
    e_r = z; e_hit = 0; e_idx = 0; e_pfn = 0; e_fl = 0;
  endtask

  task automatic model_edge();
    int q[$];
    if (data_tlbReq_i) begin
      q = m.find_first_index(item) with (item.occ && item.vpn2 == data_vpn2_i &&
                                          (item.g || item.asid == data_asid_i));
      if (q.size() > 0) begin
        e_hit = 1; e_idx = 4'(q[0]);
        e_pfn = data_oddPage_i ? m[q[0]].pfn1 : m[q[0]].pfn0;
        e_fl  = data_oddPage_i ? m[q[0]].f1   : m[q[0]].f0;
      end else begin
        e_hit = 0; e_idx = 0; e_pfn = 0; e_fl = 0;
      end
    end
    if (r_enable_i) e_r = m[r_index_i];
    if (w_enable_i)
      m[w_index_i] = '{1'b1, w_vpn2_i, w_asid_i, w_mask_i, w_g_i,
                       w_pfn0_i, w_flags0_i, w_pfn1_i, w_flags1_i};
  endtask

  task automatic chk_model();
    chk("hit", 32'(data_hit_o), 32'(e_hit));
    chk("index", 32'(data_index_o), 32'(e_idx));
    chk("pfn", 32'(data_pfn_o), 32'(e_pfn));
    chk("cdv", 32'({data_c_o, data_d_o, data_v_o}), 32'(e_fl));
    chk("r_vpn2", 32'(r_vpn2_o), 32'(e_r.vpn2));
    chk("r_asid", 32'(r_asid_o), 32'(e_r.asid));
    chk("r_mask", 32'(r_mask_o), 32'(e_r.mask));
    chk("r_g", 32'(r_g_o), 32'(e_r.g));
    chk("r_page0", 32'({r_pfn0_o, r_flags0_o}), 32'({e_r.pfn0, e_r.f0}));
    chk("r_page1", 32'({r_pfn1_o, r_flags1_o}), 32'({e_r.pfn1, e_r.f1}));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hit"}, 32'(data_hit_o), 0);
    chk({tag, "_index"}, 32'(data_index_o), 0);
    chk({tag, "_pfn"}, 32'(data_pfn_o), 0);
    chk({tag, "_cdv"}, 32'({data_c_o, data_d_o, data_v_o}), 0);
    chk({tag, "_rvpn"}, 32'(r_vpn2_o), 0);
    chk({tag, "_rrest"}, 32'({r_asid_o, r_mask_o, r_g_o}), 0);
    chk({tag, "_rpages"}, 32'({r_pfn0_o, r_flags0_o, r_pfn1_o, r_flags1_o}), 0);
  endtask

  initial begin
    // we idx vpn asid g pfn0 f0 pfn1 f1 | req vpn asid odd | re ridx | hit idx pfn c d v | rvpn
    tbl[0]  = mk(0,0,0,0,0, 0,0,0,0,                          1,0,0,0, 0,0, 0,0,0,0,0,0, 0);
    tbl[1]  = mk(1,3,19'h12345,8'h5A,0, 20'h00ABC,5'h0F,20'h00DEF,5'h09, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0);
    tbl[2]  = mk(0,0,0,0,0, 0,0,0,0,  1,19'h12345,8'h5A,0, 0,0, 1,3,20'h00ABC,3,1,1, 0);
    tbl[3]  = mk(0,0,0,0,0, 0,0,0,0,  1,19'h12345,8'h5A,1, 0,0, 1,3,20'h00DEF,2,0,1, 0);
    tbl[4]  = mk(0,0,0,0,0, 0,0,0,0,  1,19'h12345,8'h11,0, 0,0, 0,0,0,0,0,0, 0);
    tbl[5]  = mk(1,3,19'h12345,8'h5A,1, 20'h00ABC,5'h0F,20'h00DEF,5'h09, 0,0,0,0, 0,0, 0,0,0,0,0,0, 0);
    tbl[6]  = mk(0,0,0,0,0, 0,0,0,0,  1,19'h12345,8'h11,0, 0,0, 1,3,20'h00ABC,3,1,1, 0);
    tbl[7]  = mk(1,5,19'h00777,8'h00,0, 20'h55555,5'h1F,20'h0,5'h0, 1,19'h00777,8'h00,0, 1,5, 0,0,0,0,0,0, 0);
    tbl[8]  = mk(0,0,0,0,0, 0,0,0,0,  1,19'h00777,8'h00,0, 1,5, 1,5,20'h55555,7,1,1, 19'h00777);
    tbl[9]  = mk(1,2,19'h0AAAA,8'h33,0, 20'h00222,5'h1F,20'h0,5'h0, 0,0,0,0, 0,0, 1,5,20'h55555,7,1,1, 19'h00777);
    tbl[10] = mk(1,9,19'h0AAAA,8'h33,0, 20'h00999,5'h03,20'h0,5'h0, 0,0,0,0, 0,0, 1,5,20'h55555,7,1,1, 19'h00777);
    tbl[11] = mk(0,0,0,0,0, 0,0,0,0,  1,19'h0AAAA,8'h33,0, 0,0, 1,2,20'h00222,7,1,1, 19'h00777);
    tbl[12] = mk(0,0,0,0,0, 0,0,0,0,  0,19'h12345,8'h5A,1, 0,0, 1,2,20'h00222,7,1,1, 19'h00777);
    tbl[13] = mk(0,0,0,0,0, 0,0,0,0,  0,19'h00777,8'h00,0, 0,3, 1,2,20'h00222,7,1,1, 19'h00777);
    tbl[14] = mk(0,0,0,0,0, 0,0,0,0,  0,19'h0AAAA,8'h33,1, 0,0, 1,2,20'h00222,7,1,1, 19'h00777);

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    for (int k = 0; k < 15; k++) begin
      drive_vec(tbl[k]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_hit", k), 32'(data_hit_o), 32'(tbl[k].ehit));
      chk($sformatf("v%0d_index", k), 32'(data_index_o), 32'(tbl[k].eidx));
      chk($sformatf("v%0d_pfn", k), 32'(data_pfn_o), 32'(tbl[k].epfn));
      chk($sformatf("v%0d_cdv", k), 32'({data_c_o, data_d_o, data_v_o}),
          32'({tbl[k].ec, tbl[k].ed, tbl[k].ev}));
      chk($sformatf("v%0d_rvpn", k), 32'(r_vpn2_o), 32'(tbl[k].ervpn));
    end

    // Asynchronous reset between edges while outputs are non-zero.
    data_tlbReq_i = 0; r_enable_i = 0; w_enable_i = 0;
    #3 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    data_tlbReq_i = 1; data_vpn2_i = 19'h12345; data_asid_i = 8'h5A; data_oddPage_i = 0;
    @(posedge clk);
    #1;
    chk("post_rst_hit", 32'(data_hit_o), 0);
    chk("post_rst_pfn", 32'(data_pfn_o), 0);

    // Random traffic with a small tag pool so hits, aliases and ASID misses occur.
    model_reset();
    for (int n = 0; n < 400; n++) begin
      w_enable_i = ($urandom_range(0, 2) == 0);
      w_index_i = 4'($urandom_range(0, 15));
      w_vpn2_i = 19'h100 + 19'($urandom_range(0, 5));
      w_asid_i = 8'($urandom_range(0, 3));
      w_mask_i = 12'($urandom);
      w_g_i = ($urandom_range(0, 3) == 0);
      w_pfn0_i = 20'($urandom); w_pfn1_i = 20'($urandom);
      w_flags0_i = 5'($urandom); w_flags1_i = 5'($urandom);
      data_tlbReq_i = ($urandom_range(0, 3) != 0);
      data_vpn2_i = 19'h100 + 19'($urandom_range(0, 6));
      data_asid_i = 8'($urandom_range(0, 3));
      data_oddPage_i = 1'($urandom);
      r_enable_i = 1'($urandom);
      r_index_i = 4'($urandom_range(0, 15));
      model_edge();
      @(posedge clk);
      #1;
      chk_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
